router_input_port: RTL and testbench
====================================

Name: router_input_port

Overview:
- Per-input-port flit buffer and packet route holder, directly upstream of the XY route-compute block in each mesh router.
- Buffers incoming flits in a FIFO and presents the head flit's 8-bit destination to route compute.
- Latches the returned one-hot port request for the whole packet (wormhole) and streams flits to the switch under a valid/grant handshake.

Parameters:
- FLIT_W, 10, flit width: [9:8] type (2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 head+tail), [7:0] payload
- DEPTH, 4, FIFO depth in flits, power of two, at least 2
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_flit  in  FLIT_W  flit from upstream link
- in_valid  in  1  in_flit valid
- in_ready  out  1  FIFO can accept; transfer when in_valid && in_ready
- route_hdr  out  8  head-flit payload to route compute: [3:0] dest x, [7:4] dest y
- route_req_in  in  5  one-hot port from route compute, bit0..4 = L,E,W,S,N
- out_flit  out  FLIT_W  flit to switch, 0 when out_valid=0
- out_valid  out  1  out_flit valid
- out_req  out  5  latched one-hot output-port request for the current packet
- out_grant  in  1  switch accepts out_flit this cycle
- hdr_err  out  1  one-cycle pulse: non-head flit discarded in IDLE
- route_err  out  1  one-cycle pulse: illegal route (ROUTE_CHECK_EN only, else 0)

Behaviour:
- Reset (rst_n=0 at posedge): pointers and count cleared, state IDLE, req register 0. in_ready=1; out_valid, out_req, hdr_err and route_err all 0. Reset mid-packet discards all buffered flits.
- FIFO:
  - in_ready = (count != DEPTH), registered state only. A write is blocked when the FIFO is full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
  - No bypass: a written flit becomes visible at the FIFO head the next cycle.
- route_hdr = head-entry payload[7:0] at all times, combinational from FIFO head.
- FSM states: IDLE, ROUTE, ACTIVE, DRAIN (DRAIN is used only with the optional feature).
  - IDLE, FIFO empty: stay.
  - IDLE, head type 10 or 11: go to ROUTE.
  - IDLE, head type 00 or 01: pop and discard it, pulse hdr_err, stay in IDLE.
  - ROUTE: req <= route_req_in; go to ACTIVE. out_valid=0.
  - ACTIVE: out_req=req; out_valid = FIFO non-empty; out_flit = head. Pop when out_valid && out_grant.
  - ACTIVE, popped flit type 01 or 11: go to IDLE and clear req the same edge, so out_req=0 the next cycle.
  - ACTIVE, head type 10 arrives before a tail: forwarded as data. No error checking in ACTIVE.
- Latency: a head accepted at edge N gives out_valid=1 in the cycle after edge N+2 (3 cycles), with out_grant held high.
- Throughput: one flit per cycle in ACTIVE. The IDLE/ROUTE states cost 2 bubble cycles per packet.
- out_req is held stable for the whole packet, including cycles where out_valid=0 because the FIFO is empty.

Optional Feature:
- Macro: ROUTE_CHECK_EN.
- Defined:
  - In ROUTE, if route_req_in is not exactly one-hot: pulse route_err, req <= 0, enter DRAIN.
  - DRAIN: out_valid=0; pop one flit per cycle while non-empty; return to IDLE after popping type 01/11. If the head was type 11, go directly to IDLE after popping it in ROUTE.
- Undefined: route_req_in is latched unchecked, there is no DRAIN state, and route_err is tied to 0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_req=5'b00000, no flit accepted afterward beyond those sent after release.
- 3-flit packet: head 10_00010000, body 00_000000AA, tail 01_000000BB; route_req_in=5'b00001; out_grant=1 -> route_hdr=8'h10; out_req=00001 and out_valid=1 3 cycles after head accept; 3 flits emitted on consecutive cycles; out_req=0 the cycle after the tail.
- Backpressure: DEPTH=4, out_grant=0, 5 flits offered back-to-back -> in_ready=0 after the 4th accept, 5th held. Assert out_grant one cycle -> one pop, in_ready=1 the next cycle, 5th accepted.
- Stray flit: body 00_00000033 arrives in IDLE -> hdr_err high exactly 1 cycle, FIFO empty afterward, out_valid stays 0.
- Back-to-back single-flit packets: 11_00000001 (req 00010) then 11_00010000 (req 00001) -> two outputs with out_req 00010 then 00001, each preceded by 2 bubble cycles.
- ROUTE_CHECK_EN defined, route_req_in=5'b00000 on a 3-flit packet -> route_err pulses once, all 3 flits drained, out_valid never 1, returns to IDLE. Macro undefined: out_req=00000, out_valid=1 for all 3 flits.

Source files
------------

// File: rtl/router_input_port.sv
// Input-port flit FIFO plus wormhole route holder feeding the XY route-compute block and the switch.
// Optional macro ROUTE_CHECK_EN: reject non-one-hot routes and drain the offending packet.
module router_input_port #(
    parameter int FLIT_W = 10,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        route_hdr,
    input  logic [4:0]        route_req_in,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    output logic [4:0]        out_req,
    input  logic              out_grant,
    output logic              hdr_err,
    output logic              route_err
);

`ifdef ROUTE_CHECK_EN
    typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} state_t;
`endif

    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic [4:0]        req_reg;
    logic [4:0]        req_next;
    state_t            state_reg;
    state_t            state_next;

    logic              push;
    logic              pop;
    logic              empty;
    logic [FLIT_W-1:0] head;
    logic              is_head;
    logic              is_tail;

    // Full is judged on registered count only, so a same-cycle pop never frees a slot early.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign push      = in_valid && in_ready;
    assign empty     = (count_reg == '0);
    assign head      = mem[rd_ptr_reg];
    assign is_head   = head[FLIT_W-1];
    assign is_tail   = head[FLIT_W-2];
    assign route_hdr = head[7:0];
    assign out_req   = req_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            req_reg    <= '0;
            state_reg  <= IDLE;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            req_reg   <= req_next;
            state_reg <= state_next;
        end
    end

`ifdef ROUTE_CHECK_EN
    logic route_err_c;
    logic req_onehot;
    assign req_onehot = (route_req_in != 5'b0) && ((route_req_in & (route_req_in - 5'd1)) == 5'b0);
    assign route_err  = route_err_c;
`else
    assign route_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        pop        = 1'b0;
        out_valid  = 1'b0;
        out_flit   = '0;
        hdr_err    = 1'b0;
`ifdef ROUTE_CHECK_EN
        route_err_c = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    if (is_head) begin
                        state_next = ROUTE;
                    end else begin
                        pop     = 1'b1;
                        hdr_err = 1'b1;
                    end
                end
            end
            ROUTE: begin
`ifdef ROUTE_CHECK_EN
                if (req_onehot) begin
                    req_next   = route_req_in;
                    state_next = ACTIVE;
                end else begin
                    // Discard the head here; a single-flit packet is then already gone.
                    route_err_c = 1'b1;
                    req_next    = '0;
                    pop         = 1'b1;
                    state_next  = is_tail ? IDLE : DRAIN;
                end
`else
                req_next   = route_req_in;
                state_next = ACTIVE;
`endif
            end
            ACTIVE: begin
                out_valid = !empty;
                if (!empty) out_flit = head;
                if (!empty && out_grant) begin
                    pop = 1'b1;
                    if (is_tail) begin
                        state_next = IDLE;
                        req_next   = '0;
                    end
                end
            end
`ifdef ROUTE_CHECK_EN
            DRAIN: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (is_tail) state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_router_input_port.sv
// Directed self-checking bench for router_input_port: reset, packet flow, backpressure, stray flits, route check.
module tb_router_input_port;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] in_flit;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] route_hdr;
    logic [4:0] route_req_in;
    logic [9:0] out_flit;
    logic       out_valid;
    logic [4:0] out_req;
    logic       out_grant;
    logic       hdr_err;
    logic       route_err;

    int total = 0;
    int bad   = 0;

    router_input_port #(.FLIT_W(10), .DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .route_hdr(route_hdr), .route_req_in(route_req_in),
        .out_flit(out_flit), .out_valid(out_valid), .out_req(out_req),
        .out_grant(out_grant), .hdr_err(hdr_err), .route_err(route_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_grant)
            $display("xfer: out_flit=%h out_req=%b", out_flit, out_req);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_flit = 10'b10_0000_0101;
        route_req_in = 5'b00001; out_grant = 1'b1;
        tick(); tick();
        rst_n = 1'b1; in_valid = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_req !== 5'b00000) begin bad++; $display("FAIL reset_out_req: got %b want 00000", out_req); end
        total++; if (hdr_err !== 1'b0 || route_err !== 1'b0) begin bad++; $display("FAIL reset_errs: got %b%b want 00", hdr_err, route_err); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL reset_idle: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
        end
    endtask

    task automatic test_packet();
        out_grant = 1'b1; route_req_in = 5'b00001;
        in_valid = 1'b1; in_flit = 10'b10_0001_0000;
        tick();
        total++; if (route_hdr !== 8'h10) begin bad++; $display("FAIL pkt_route_hdr: got %h want 10", route_hdr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pkt_lat_idle: got %b want 0", out_valid); end
        in_flit = {2'b00, 8'hAA};
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pkt_lat_route: got %b want 0", out_valid); end
        in_flit = {2'b01, 8'hBB};
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_flit !== 10'b10_0001_0000) begin bad++; $display("FAIL pkt_head_out: got %b %h want 1 210", out_valid, out_flit); end
        total++; if (out_req !== 5'b00001) begin bad++; $display("FAIL pkt_out_req: got %b want 00001", out_req); end
        tick();
        total++; if (out_valid !== 1'b1 || out_flit !== {2'b00, 8'hAA}) begin bad++; $display("FAIL pkt_body_out: got %b %h want 1 0aa", out_valid, out_flit); end
        tick();
        total++; if (out_valid !== 1'b1 || out_flit !== {2'b01, 8'hBB}) begin bad++; $display("FAIL pkt_tail_out: got %b %h want 1 1bb", out_valid, out_flit); end
        total++; if (out_req !== 5'b00001) begin bad++; $display("FAIL pkt_req_hold: got %b want 00001", out_req); end
        tick();
        total++; if (out_valid !== 1'b0 || out_req !== 5'b00000 || out_flit !== 10'h000) begin bad++; $display("FAIL pkt_after_tail: got %b %b %h want 0 00000 000", out_valid, out_req, out_flit); end
    endtask

    task automatic test_backpressure();
        logic [9:0] f [5];
        f[0] = {2'b10, 8'h22}; f[1] = {2'b00, 8'h01}; f[2] = {2'b00, 8'h02};
        f[3] = {2'b00, 8'h03}; f[4] = {2'b01, 8'h04};
        out_grant = 1'b0; route_req_in = 5'b00100;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_flit = f[i];
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept%0d: got ready=%b want 1", i, in_ready); end
            tick();
        end
        in_flit = f[4];
        for (int i = 0; i < 2; i++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full%0d: got ready=%b want 0", i, in_ready); end
            tick();
        end
        total++; if (out_valid !== 1'b1 || out_flit !== f[0] || out_req !== 5'b00100) begin bad++; $display("FAIL bp_stalled_head: got %b %h %b want 1 %h 00100", out_valid, out_flit, out_req, f[0]); end
        out_grant = 1'b1;
        tick();
        out_grant = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop: got %b want 1", in_ready); end
        total++; if (out_flit !== f[1]) begin bad++; $display("FAIL bp_next_head: got %h want %h", out_flit, f[1]); end
        tick();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_fifth_taken: got ready=%b want 0", in_ready); end
        out_grant = 1'b1;
        for (int i = 1; i < 5; i++) begin
            total++; if (out_valid !== 1'b1 || out_flit !== f[i]) begin bad++; $display("FAIL bp_drain%0d: got %b %h want 1 %h", i, out_valid, out_flit, f[i]); end
            tick();
        end
        total++; if (out_valid !== 1'b0 || out_req !== 5'b00000) begin bad++; $display("FAIL bp_end: got %b %b want 0 00000", out_valid, out_req); end
    endtask

    task automatic test_stray();
        out_grant = 1'b1;
        in_valid = 1'b1; in_flit = {2'b00, 8'h33};
        tick();
        in_valid = 1'b0;
        total++; if (hdr_err !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL stray_pulse: got err=%b valid=%b want 1 0", hdr_err, out_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (hdr_err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL stray_after%0d: got err=%b valid=%b ready=%b want 0 0 1", i, hdr_err, out_valid, in_ready); end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] rq [7];
        logic       ev [7];
        logic [4:0] er [7];
        logic [9:0] ef [7];
        rq = '{5'b0, 5'b00010, 5'b0, 5'b0, 5'b00001, 5'b0, 5'b0};
        ev = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        er = '{5'b0, 5'b0, 5'b00010, 5'b0, 5'b0, 5'b00001, 5'b0};
        ef = '{10'h0, 10'h0, 10'h301, 10'h0, 10'h0, 10'h310, 10'h0};
        out_grant = 1'b1;
        in_valid = 1'b1; in_flit = 10'h301;
        tick();
        in_flit = 10'h310;
        for (int i = 0; i < 7; i++) begin
            route_req_in = rq[i];
            total++; if (out_valid !== ev[i] || out_req !== er[i] || out_flit !== ef[i]) begin bad++; $display("FAIL b2b_cycle%0d: got %b %b %h want %b %b %h", i, out_valid, out_req, out_flit, ev[i], er[i], ef[i]); end
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic test_route_check();
        logic [9:0] f [3];
        int errs;
        int outs;
        f[0] = 10'b10_0001_0000; f[1] = {2'b00, 8'hAA}; f[2] = {2'b01, 8'hBB};
        errs = 0; outs = 0;
        out_grant = 1'b1; route_req_in = 5'b00000;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_flit = (i < 3) ? f[i] : 10'h0;
            in_valid = (i < 3);
            tick();
            in_valid = 1'b0;
            if (route_err === 1'b1) errs++;
`ifndef ROUTE_CHECK_EN
            if (i >= 2 && i <= 4) begin
                total++; if (out_valid !== 1'b1 || out_flit !== f[i-2] || out_req !== 5'b00000) begin bad++; $display("FAIL rc_unchecked%0d: got %b %h %b want 1 %h 00000", i, out_valid, out_flit, out_req, f[i-2]); end
            end
`endif
            if (out_valid === 1'b1) outs++;
        end
`ifdef ROUTE_CHECK_EN
        total++; if (errs !== 1) begin bad++; $display("FAIL rc_err_pulses: got %0d want 1", errs); end
        total++; if (outs !== 0) begin bad++; $display("FAIL rc_out_valid_cycles: got %0d want 0", outs); end
`else
        total++; if (errs !== 0) begin bad++; $display("FAIL rc_err_tied: got %0d want 0", errs); end
        total++; if (outs !== 3) begin bad++; $display("FAIL rc_out_valid_cycles: got %0d want 3", outs); end
`endif
        total++; if (in_ready !== 1'b1 || out_req !== 5'b00000 || out_valid !== 1'b0) begin bad++; $display("FAIL rc_back_idle: got %b %b %b want 1 00000 0", in_ready, out_req, out_valid); end
        // A fresh packet must route normally, proving the FIFO and FSM are clean.
        route_req_in = 5'b01000;
        in_valid = 1'b1; in_flit = 10'h3_55;
        tick(); in_valid = 1'b0;
        tick(); tick();
        total++; if (out_valid !== 1'b1 || out_flit !== 10'h355 || out_req !== 5'b01000) begin bad++; $display("FAIL rc_next_pkt: got %b %h %b want 1 355 01000", out_valid, out_flit, out_req); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_flit = '0; route_req_in = '0; out_grant = 1'b0;
        test_reset();
        test_packet();
        test_backpressure();
        test_stray();
        test_back_to_back();
        test_route_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
